// File: rtl/vx_prefetch_queue_pkg.sv
// Shared types for the per-bank prefetch queue: slot state encoding, timer sizing, slot record.
package VX_prefetch_pkg;

   typedef enum logic [1:0] {
      PF_FREE    = 2'd0,
      PF_PENDING = 2'd1,
      PF_ISSUED  = 2'd2
   } pf_state_t;

   // Timer must be able to hold the value TIMEOUT itself.
   function automatic int pf_timer_w(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

   localparam int PF_LINE_ADDRW = 26;
   localparam int PF_TIMEOUT    = 255;
   localparam int PF_TIMER_W    = pf_timer_w(PF_TIMEOUT);

   typedef struct packed {
      pf_state_t               state;
      logic [PF_LINE_ADDRW-1:0] addr;
      logic [PF_TIMER_W-1:0]   timer;
   } pf_entry_t;

endpackage

// File: rtl/vx_prefetch_queue_entry.sv
// One prefetch tracker slot: FREE -> PENDING on alloc, -> ISSUED on handshake, back to FREE on
// cancel, fill or timeout. Exposes its next-state occupancy so the top can register busy.
module VX_prefetch_entry
   import VX_prefetch_pkg::*;
#(
   parameter int LINE_ADDRW = 26,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  alloc_i,
   input  logic [LINE_ADDRW-1:0] alloc_addr_i,
   input  logic                  issue_ack_i,
   input  logic                  cancel_hit_i,
   input  logic                  fill_hit_i,
   output pf_state_t             state_o,
   output logic [LINE_ADDRW-1:0] addr_o,
   output logic                  busy_d_o
);

   localparam int TW = pf_timer_w(TIMEOUT);

   pf_state_t             state_q, state_d;
   logic [LINE_ADDRW-1:0] addr_q, addr_d;
   logic [TW-1:0]         timer_q, timer_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      timer_d = timer_q;
      unique case (state_q)
         PF_FREE: begin
            if (alloc_i) begin
               state_d = PF_PENDING;
               addr_d  = alloc_addr_i;
               timer_d = '0;
            end
         end
         PF_PENDING: begin
            // A fill means the line is already present; an issue beats a demand cancel.
            if (fill_hit_i) begin
               state_d = PF_FREE;
            end else if (issue_ack_i) begin
               state_d = PF_ISSUED;
               timer_d = '0;
            end else if (cancel_hit_i) begin
               state_d = PF_FREE;
            end
         end
         PF_ISSUED: begin
            if (fill_hit_i) begin
               state_d = PF_FREE;
            end else begin
               if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + TW'(1);
               if (timer_q >= TW'(TIMEOUT - 1)) state_d = PF_FREE;
            end
         end
         default: state_d = PF_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PF_FREE;
         addr_q  <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         timer_q <= timer_d;
      end
   end

   assign state_o  = state_q;
   assign addr_o   = addr_q;
   assign busy_d_o = (state_d != PF_FREE);

endmodule

// File: rtl/vx_prefetch_queue.sv
// Per-bank prefetch queue: drops duplicate/overflow hints, issues lowest PENDING slot to the bank.
// Hints never back-pressured; issue held until pf_out_ready. Perf counters under VX_PREFETCH_PERF_EN.
module vx_prefetch_queue
   import VX_prefetch_pkg::*;
#(
   parameter int CACHE_ID    = 0,
   parameter int BANK_ID     = 0,
   parameter int LINE_ADDRW  = 26,
   parameter int NUM_ENTRIES = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pf_req_valid,
   input  logic [LINE_ADDRW-1:0] pf_req_addr,
   output logic                  pf_req_ready,
   output logic                  pf_out_valid,
   output logic [LINE_ADDRW-1:0] pf_out_addr,
   input  logic                  pf_out_ready,
   input  logic                  core_lookup_valid,
   input  logic [LINE_ADDRW-1:0] core_lookup_addr,
   input  logic                  fill_valid,
   input  logic [LINE_ADDRW-1:0] fill_addr,
   input  logic                  evict_valid,
   input  logic                  evict_used,
`ifdef VX_PREFETCH_PERF_EN
   output logic [31:0]           perf_pf_dropped,
   output logic [31:0]           perf_pf_issued,
   output logic [31:0]           perf_pf_unused_evict,
`endif
   output logic                  busy
);

   localparam int IDXW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   pf_state_t             slot_state [NUM_ENTRIES];
   logic [LINE_ADDRW-1:0] slot_addr  [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] free_v, pend_v, live_match, cancel_hit, fill_hit;
   logic [NUM_ENTRIES-1:0] alloc_sel, alloc, issue_ack, busy_nxt;
   logic [IDXW-1:0]        pend_idx;
   logic                   ready_q, busy_q;
   logic                   hint_acc, hint_drop, issue_fire, found_free, found_pend;

   always_comb begin
      free_v     = '0;
      pend_v     = '0;
      live_match = '0;
      cancel_hit = '0;
      fill_hit   = '0;
      alloc_sel  = '0;
      pend_idx   = '0;
      found_free = 1'b0;
      found_pend = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         free_v[i]     = (slot_state[i] == PF_FREE);
         pend_v[i]     = (slot_state[i] == PF_PENDING);
         live_match[i] = !free_v[i] && (slot_addr[i] == pf_req_addr);
         cancel_hit[i] = core_lookup_valid && pend_v[i] && (slot_addr[i] == core_lookup_addr);
         fill_hit[i]   = fill_valid && !free_v[i] && (slot_addr[i] == fill_addr);
         if (free_v[i] && !found_free) begin
            alloc_sel[i] = 1'b1;
            found_free   = 1'b1;
         end
         if (pend_v[i] && !found_pend) begin
            pend_idx   = IDXW'(i);
            found_pend = 1'b1;
         end
      end
   end

   assign hint_acc   = pf_req_valid && ready_q;
   assign hint_drop  = hint_acc && (!found_free || (|live_match)
                       || (fill_valid && (fill_addr == pf_req_addr))
                       || (core_lookup_valid && (core_lookup_addr == pf_req_addr)));
   assign alloc      = (hint_acc && !hint_drop) ? alloc_sel : '0;
   assign issue_fire = pf_out_valid && pf_out_ready;

   always_comb begin
      issue_ack = '0;
      if (issue_fire) issue_ack[pend_idx] = 1'b1;
   end

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_slot
      VX_prefetch_entry #(
         .LINE_ADDRW (LINE_ADDRW),
         .TIMEOUT    (TIMEOUT)
      ) u_entry (
         .clk          (clk),
         .rst_ni       (reset),
         .alloc_i      (alloc[g]),
         .alloc_addr_i (pf_req_addr),
         .issue_ack_i  (issue_ack[g]),
         .cancel_hit_i (cancel_hit[g]),
         .fill_hit_i   (fill_hit[g]),
         .state_o      (slot_state[g]),
         .addr_o       (slot_addr[g]),
         .busy_d_o     (busy_nxt[g])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         busy_q  <= |busy_nxt;
      end
   end

   assign pf_req_ready = ready_q;
   assign pf_out_valid = found_pend;
   assign pf_out_addr  = slot_addr[pend_idx];
   assign busy         = busy_q;

`ifdef VX_PREFETCH_PERF_EN
   logic [31:0] drop_cnt_q, issue_cnt_q, unused_evict_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt_q         <= '0;
         issue_cnt_q        <= '0;
         unused_evict_cnt_q <= '0;
      end else begin
         if (hint_drop)                 drop_cnt_q         <= drop_cnt_q + 32'd1;
         if (issue_fire)                issue_cnt_q        <= issue_cnt_q + 32'd1;
         if (evict_valid && !evict_used) unused_evict_cnt_q <= unused_evict_cnt_q + 32'd1;
      end
   end

   assign perf_pf_dropped      = drop_cnt_q;
   assign perf_pf_issued       = issue_cnt_q;
   assign perf_pf_unused_evict = unused_evict_cnt_q;
`else
   logic unused_evict;
   assign unused_evict = evict_valid ^ evict_used;
`endif

   logic [31:0] unused_ids;
   assign unused_ids = 32'(CACHE_ID) ^ 32'(BANK_ID);

endmodule
